serializer8: RTL and testbench

SERIALIZER8 -- requirements
Module: serializer8

---
 rtl/serializer_pkg.sv | 10 +
 rtl/multiplexer8x1.sv | 8 +
 rtl/serializer8.sv | 84 ++++++++
 tb/tb_serializer8.sv | 133 +++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared widths and FSM encoding for the 8-bit serializer.
package serializer_pkg;
  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/multiplexer8x1.sv
// 8-to-1 bit multiplexer: y = w[s].
module multiplexer8x1 (
  input  logic [7:0] w,
  input  logic [2:0] s,
  output logic       y
);
  assign y = w[s];
endmodule

// File: rtl/serializer8.sv
// Parallel-to-serial converter with valid/ready on both sides; one bit per beat,
// back-to-back words with no bubble when a new word arrives on the last beat.
import serializer_pkg::*;

module serializer8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  input  logic              sout_ready,
  output logic              sout_last,
  output logic              busy
);
  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WORD_W-1) : '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? '0 : SEL_W'(WORD_W-1);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] word, word_nxt;
  logic [SEL_W-1:0]  sel, sel_nxt;
  logic              mux_y;
  logic              accept;

  assign busy       = (state == SHIFT);
  assign sout_valid = busy;
  assign sout_last  = busy && (sel == SEL_LAST);
  // Only the final beat of a word can hand off to the next one.
  assign din_ready  = !busy || (sout_last && sout_ready);
  assign accept     = din_valid && din_ready;

  multiplexer8x1 u_mux (
    .w (word),
    .s (sel),
    .y (mux_y)
  );

  assign sout = busy & mux_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (accept) begin
          word_nxt  = din;
          sel_nxt   = SEL_FIRST;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sout_ready) begin
          if (sout_last) begin
            if (accept) begin
              word_nxt = din;
              sel_nxt  = SEL_FIRST;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sel_nxt = MSB_FIRST ? sel - SEL_W'(1) : sel + SEL_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serializer8.sv
// Bench for serializer8: LSB-first and MSB-first instances driven in lockstep and
// compared every cycle against a bits-remaining model of the serial stream.
module tb_serializer8;
  logic       clk = 1'b0;
  logic       reset, din_valid, sout_ready;
  logic [7:0] din;
  logic       d0_din_ready, d0_sout, d0_sout_valid, d0_sout_last, d0_busy;
  logic       d1_din_ready, d1_sout, d1_sout_valid, d1_sout_last, d1_busy;

  int checks = 0;
  int errors = 0;

  // model: bits still to send (0 = idle) and the word in flight
  int         m_cnt  = 0;
  logic [7:0] m_word = 8'h00;
  logic [7:0] cap0, cap1;

  always #5 clk = ~clk;

  serializer8 #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(d0_din_ready), .sout(d0_sout), .sout_valid(d0_sout_valid),
    .sout_ready(sout_ready), .sout_last(d0_sout_last), .busy(d0_busy)
  );

  serializer8 #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(d1_din_ready), .sout(d1_sout), .sout_valid(d1_sout_valid),
    .sout_ready(sout_ready), .sout_last(d1_sout_last), .busy(d1_busy)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic dv, input logic [7:0] d,
                      input logic sr, input bit chk = 1'b1);
    logic e_valid, e_last, e_ready, e_b0, e_b1;
    int   k;
    reset = r; din_valid = dv; din = d; sout_ready = sr;
    #1;
    k       = 8 - m_cnt;
    e_valid = (m_cnt > 0);
    e_last  = (m_cnt == 1);
    e_ready = (m_cnt == 0) || (m_cnt == 1 && sr);
    e_b0    = e_valid ? m_word[k] : 1'b0;
    e_b1    = e_valid ? m_word[7-k] : 1'b0;
    if (chk) begin
      check("lsb_valid", {7'd0, d0_sout_valid}, {7'd0, e_valid});
      check("lsb_busy",  {7'd0, d0_busy},       {7'd0, e_valid});
      check("lsb_last",  {7'd0, d0_sout_last},  {7'd0, e_last});
      check("lsb_ready", {7'd0, d0_din_ready},  {7'd0, e_ready});
      check("lsb_sout",  {7'd0, d0_sout},       {7'd0, e_b0});
      check("msb_valid", {7'd0, d1_sout_valid}, {7'd0, e_valid});
      check("msb_last",  {7'd0, d1_sout_last},  {7'd0, e_last});
      check("msb_ready", {7'd0, d1_din_ready},  {7'd0, e_ready});
      check("msb_sout",  {7'd0, d1_sout},       {7'd0, e_b1});
    end
    if (e_valid && sr) begin
      cap0 = {d0_sout, cap0[7:1]};
      cap1 = {cap1[6:0], d1_sout};
    end
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_word = 8'h00;
    end else if (dv && e_ready) begin
      m_word = d; m_cnt = 8;
    end else if (m_cnt > 0 && sr) begin
      m_cnt--;
    end
    @(negedge clk);
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);          // reset beats a pending accept
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // 8'b11101010 at full rate, then idle
    step(1'b0, 1'b1, 8'hEA, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("ea_lsb_stream", cap0, 8'hEA);
    check("ea_msb_stream", cap1, 8'hEA);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // A5 with sout_ready toggling
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, logic'(i[0]));
    check("a5_lsb_stream", cap0, 8'hA5);
    check("a5_msb_stream", cap1, 8'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // back-to-back 0F then F0 with din_valid held
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h0F, 1'b1);
    step(1'b0, 1'b1, 8'hF0, 1'b1);
    check("b2b_first_lsb", cap0, 8'h0F);
    check("b2b_first_msb", cap1, 8'h0F);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'hF0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_second_lsb", cap0, 8'hF0);
    check("b2b_second_msb", cap1, 8'hF0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // reset after beat 3 of FF, then 01
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    check("post_reset_lsb", cap0, 8'h01);
    check("post_reset_msb", cap1, 8'h01);

    // din changes and stray din_valid while 3C is in flight
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'hC3, 1'b1);
    step(1'b0, 1'b0, 8'hC3, 1'b1);
    check("hold_lsb", cap0, 8'h3C);
    check("hold_msb", cap1, 8'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom), ($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
